// File: rtl/lo_mask_gen.sv
// rtl/lo_mask_gen.sv - leading-ones mask generator, builds the 32-bit mask MSB-first STEP bits per cycle
// Optional macro LOMASK_INVERT_EN adds an inv input that inverts the completed mask.
module lo_mask_gen #(
  parameter int STEP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  count,
`ifdef LOMASK_INVERT_EN
  input  logic        inv,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [5:0]  ones_cnt,
  output logic        sat
);

  localparam int LAT = 32 / STEP;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [31:0]     acc;
  logic [31:0]     accNext;
  logic [31:0]     finalWord;
  logic [5:0]      chunkIdx;
  logic [STEP-1:0] chunk;
  logic            lastChunk;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign lastChunk = (chunkIdx == 6'(LAT - 1));

  // ones_cnt doubles as the saturated n for the whole RUN; it only changes on accept
  always_comb begin
    chunk = '0;
    for (int j = 0; j < STEP; j++) begin
      chunk[STEP-1-j] = ((int'(chunkIdx) * STEP + j) < int'(ones_cnt));
    end
  end

  if (STEP == 32) begin : gNoShift
    assign accNext = chunk;
  end else begin : gShift
    assign accNext = {acc[31-STEP:0], chunk};
  end

`ifdef LOMASK_INVERT_EN
  logic invLatched;
  assign finalWord = invLatched ? ~accNext : accNext;
`else
  assign finalWord = accNext;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      chunkIdx <= '0;
      result   <= '0;
      ones_cnt <= '0;
      sat      <= 1'b0;
`ifdef LOMASK_INVERT_EN
      invLatched <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            ones_cnt <= (count > 6'd32) ? 6'd32 : count;
            sat      <= (count > 6'd32);
            acc      <= '0;
            chunkIdx <= '0;
`ifdef LOMASK_INVERT_EN
            invLatched <= inv;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc      <= accNext;
          chunkIdx <= chunkIdx + 6'd1;
          if (lastChunk) begin
            result <= finalWord;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lo_mask_gen.sv
// tb/tb_lo_mask_gen.sv - self-checking bench for lo_mask_gen at STEP 4, 1, 8 and 32
// Honours LOMASK_INVERT_EN when defined.
module tb_lo_mask_gen;

`ifdef LOMASK_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  function automatic int stepOf(input int d);
    case (d)
      0: return 4;
      1: return 1;
      2: return 8;
      default: return 32;
    endcase
  endfunction

  logic        clock = 1'b0;
  logic        reset;
  logic        startS  [4];
  logic [5:0]  countS  [4];
  logic        busyS   [4];
  logic        doneS   [4];
  logic [31:0] resultS [4];
  logic [5:0]  onesS   [4];
  logic        satS    [4];
`ifdef LOMASK_INVERT_EN
  logic        invS    [4];
`endif

  logic [31:0] prevResult [4];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : gDut
    lo_mask_gen #(.STEP(stepOf(g))) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (startS[g]),
      .count    (countS[g]),
`ifdef LOMASK_INVERT_EN
      .inv      (invS[g]),
`endif
      .busy     (busyS[g]),
      .done     (doneS[g]),
      .result   (resultS[g]),
      .ones_cnt (onesS[g]),
      .sat      (satS[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mask with n leading ones: 2^32 - 2^(32-n)
  function automatic logic [31:0] expMask(input int n);
    logic [63:0] t;
    t = (64'h1 << 32) - (64'h1 << (32 - n));
    return t[31:0];
  endfunction

  function automatic int clo(input logic [31:0] w);
    int c = 0;
    for (int i = 31; i >= 0; i--) begin
      if (w[i] !== 1'b1) break;
      c++;
    end
    return c;
  endfunction

  task automatic nextCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Issues a request from the current negedge; returns at the negedge of the done cycle.
  task automatic request(input int d, input int cnt, input bit invReq, input int injAt);
    int n;
    int lat;
    bit inv;
    logic [31:0] exp;
    n   = (cnt > 32) ? 32 : cnt;
    lat = 32 / stepOf(d);
    inv = invReq & INV_EN;
    exp = inv ? ~expMask(n) : expMask(n);
    startS[d] = 1'b1;
    countS[d] = 6'(cnt);
`ifdef LOMASK_INVERT_EN
    invS[d] = inv;
`endif
    nextCycle();
    startS[d] = 1'b0;
    countS[d] = 6'($urandom);
`ifdef LOMASK_INVERT_EN
    invS[d] = 1'($urandom);
`endif
    for (int c = 1; c <= lat; c++) begin
      chk("busy_run", 32'(busyS[d]), 32'd1);
      chk("done_run", 32'(doneS[d]), 32'd0);
      chk("result_hold", resultS[d], prevResult[d]);
      chk("ones_run", 32'(onesS[d]), 32'(n));
      if (c == injAt) begin
        startS[d] = 1'b1;
        countS[d] = 6'd3;
      end
      nextCycle();
      startS[d] = 1'b0;
    end
    chk("done_pulse", 32'(doneS[d]), 32'd1);
    chk("busy_done", 32'(busyS[d]), 32'd0);
    chk("result", resultS[d], exp);
    chk("ones_cnt", 32'(onesS[d]), 32'(n));
    chk("sat", 32'(satS[d]), 32'(cnt > 32));
    chk("clo_roundtrip", 32'(inv ? clo(~resultS[d]) : clo(resultS[d])), 32'(n));
    prevResult[d] = exp;
  endtask

  task automatic idleCheck(input int d);
    nextCycle();
    chk("done_single", 32'(doneS[d]), 32'd0);
    chk("busy_idle", 32'(busyS[d]), 32'd0);
    chk("result_idle", resultS[d], prevResult[d]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 4; d++) begin
      startS[d] = 1'b0;
      countS[d] = '0;
      prevResult[d] = '0;
`ifdef LOMASK_INVERT_EN
      invS[d] = 1'b0;
`endif
    end
    repeat (3) nextCycle();
    chk("rst_busy", 32'(busyS[0]), 32'd0);
    chk("rst_done", 32'(doneS[0]), 32'd0);
    chk("rst_result", resultS[0], 32'h0);
    chk("rst_ones", 32'(onesS[0]), 32'd0);
    chk("rst_sat", 32'(satS[0]), 32'd0);
    reset = 1'b0;
    nextCycle();

    request(0, 6, 1'b0, 0);
    chk("cnt6_const", resultS[0], 32'hFC000000);
    idleCheck(0);

    request(0, 0, 1'b0, 0);
    chk("cnt0_const", resultS[0], 32'h00000000);
    request(0, 32, 1'b0, 0);
    chk("cnt32_const", resultS[0], 32'hFFFFFFFF);
    idleCheck(0);

    request(0, 45, 1'b0, 0);
    chk("cnt45_const", resultS[0], 32'hFFFFFFFF);
    chk("cnt45_sat", 32'(satS[0]), 32'd1);
    idleCheck(0);
    request(0, 1, 1'b0, 0);
    chk("cnt1_const", resultS[0], 32'h80000000);
    idleCheck(0);

    request(0, 12, 1'b0, 4);
    chk("cnt12_const", resultS[0], 32'hFFF00000);
    idleCheck(0);

    // Reset in the middle of a RUN drops the request
    startS[0] = 1'b1;
    countS[0] = 6'd20;
    nextCycle();
    startS[0] = 1'b0;
    repeat (4) nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    chk("midrst_busy", 32'(busyS[0]), 32'd0);
    chk("midrst_done", 32'(doneS[0]), 32'd0);
    chk("midrst_result", resultS[0], 32'h0);
    chk("midrst_ones", 32'(onesS[0]), 32'd0);
    for (int d = 0; d < 4; d++) prevResult[d] = '0;
    for (int c = 0; c < 12; c++) begin
      nextCycle();
      chk("midrst_nodone", 32'(doneS[0]), 32'd0);
    end
    request(0, 8, 1'b0, 0);
    chk("cnt8_const", resultS[0], 32'hFF000000);
    idleCheck(0);

`ifdef LOMASK_INVERT_EN
    request(0, 6, 1'b1, 0);
    chk("inv6_const", resultS[0], 32'h03FFFFFF);
    idleCheck(0);
`endif

    for (int r = 0; r < 24; r++) begin
      request(0, int'($urandom_range(0, 63)), 1'($urandom), 0);
      if ($urandom_range(0, 1) == 1) idleCheck(0);
    end
    idleCheck(0);

    for (int d = 1; d < 4; d++) begin
      for (int cnt = 0; cnt <= 32; cnt++) begin
        request(d, cnt, 1'(cnt), 0);
      end
      idleCheck(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
